// File: rtl/vec_len_sq_feeder.sv
// Squares and sums a signed (dx, dy) move vector with a serial shift-add multiplier, then hands the sum to the sqrt unit.
// Latency: 2*COORD_BITS enabled cycles to the sqrt_trigger, then one DONE cycle; each clk_en=0 cycle adds one cycle.
// Backpressure: holds in WAIT_RDY with num_out stable until sqrt_rdy; trigger is ignored whenever rdy=0.
module vec_len_sq_feeder #(
  parameter int COORD_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic signed [COORD_BITS-1:0] dx,
  input  logic signed [COORD_BITS-1:0] dy,
  input  logic                         trigger,
  input  logic                         sqrt_rdy,
  output logic [2*COORD_BITS-1:0]      num_out,
  output logic                         sqrt_trigger,
  output logic                         rdy,
  output logic                         done
);

  localparam int SW = 2 * COORD_BITS;
  localparam int CW = (COORD_BITS > 1) ? $clog2(COORD_BITS) : 1;

  typedef enum logic [2:0] {IDLE, SQ_X, SQ_Y, WAIT_RDY, DONE} state_t;

  state_t                state, state_nxt;
  logic [COORD_BITS-1:0] mag_x, mag_y, op;
  logic [SW-1:0]         acc, addend, sum;
  logic [CW-1:0]         cnt;
  logic                  last_bit;

  // -2^(C-1) negates to itself, which read as unsigned is exactly 2^(C-1).
  function automatic logic [COORD_BITS-1:0] abs_mag(input logic signed [COORD_BITS-1:0] v);
    return v[COORD_BITS-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  always_comb begin
    op       = (state == SQ_Y) ? mag_y : mag_x;
    addend   = op[cnt] ? (SW'(op) << cnt) : '0;
    sum      = acc + addend;
    last_bit = (cnt == CW'(COORD_BITS - 1));
  end

  always_comb begin
    state_nxt    = state;
    rdy          = (state == IDLE);
    done         = (state == DONE);
    sqrt_trigger = (state == WAIT_RDY) && sqrt_rdy && clk_en;
    case (state)
      IDLE:     if (trigger)  state_nxt = SQ_X;
      SQ_X:     if (last_bit) state_nxt = SQ_Y;
      SQ_Y:     if (last_bit) state_nxt = WAIT_RDY;
      WAIT_RDY: if (sqrt_rdy) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mag_x   <= '0;
      mag_y   <= '0;
      acc     <= '0;
      cnt     <= '0;
      num_out <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (trigger) begin
            mag_x <= abs_mag(dx);
            mag_y <= abs_mag(dy);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        SQ_X, SQ_Y: begin
          acc <= sum;
          cnt <= last_bit ? '0 : cnt + 1'b1;
          if (state == SQ_Y && last_bit) num_out <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_len_sq_feeder.sv
// Bench for vec_len_sq_feeder: 8-bit instance with scoreboard and directed corner cases, 4-bit instance swept exhaustively.
module tb_vec_len_sq_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clk_en, trigger, sqrt_rdy;
  logic signed [7:0] dx, dy;
  logic [15:0]       num_out;
  logic              sqrt_trigger, rdy, done;

  logic              reset4, en4, trig4, srdy4;
  logic signed [3:0] dx4, dy4;
  logic [7:0]        num4;
  logic              st4, rdy4, done4;

  vec_len_sq_feeder #(.COORD_BITS(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .dx(dx), .dy(dy), .trigger(trigger),
    .sqrt_rdy(sqrt_rdy), .num_out(num_out), .sqrt_trigger(sqrt_trigger), .rdy(rdy), .done(done));

  vec_len_sq_feeder #(.COORD_BITS(4)) dut4 (
    .clk(clk), .reset(reset4), .clk_en(en4), .dx(dx4), .dy(dy4), .trigger(trig4),
    .sqrt_rdy(srdy4), .num_out(num4), .sqrt_trigger(st4), .rdy(rdy4), .done(done4));

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int last_res = 0;

  typedef struct {
    logic signed [7:0] dx;
    logic signed [7:0] dy;
    int                exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and handshake invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rdy_done_excl", int'(rdy && done), 0);
      if (sqrt_trigger) begin
        chk("trig_qualified", int'(sqrt_rdy && clk_en && !rdy && !done), 1);
        if (exp_q.size() == 0) chk("trig_unexpected", int'(sqrt_trigger), 0);
        else chk("num_out", int'(num_out), exp_q.pop_front());
      end
    end
    if (!reset4) begin
      chk("rdy_done_excl4", int'(rdy4 && done4), 0);
      if (st4) chk("trig_qualified4", int'(!rdy4 && !done4), 1);
    end
  end

  task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b, input int exp,
                        input string name);
    int n;
    dx = a; dy = b; trigger = 1'b1;
    exp_q.push_back(exp);
    tick();
    trigger = 1'b0;
    n = 0;
    while (!sqrt_trigger && n < 100) begin
      tick();
      n++;
      if (n == 8) chk({name, "_hold"}, int'(num_out), last_res);
    end
    chk({name, "_lat"}, n, 16);
    tick();
    chk({name, "_done"}, int'(done && !sqrt_trigger), 1);
    tick();
    chk({name, "_rdy"}, int'(rdy && !done), 1);
    last_res = exp;
  endtask

  task automatic run4(input logic signed [3:0] a, input logic signed [3:0] b, input int exp);
    int n;
    dx4 = a; dy4 = b; trig4 = 1'b1;
    tick();
    trig4 = 1'b0;
    n = 0;
    while (!st4 && n < 50) begin
      tick();
      n++;
    end
    chk("c4_lat", n, 8);
    chk("c4_num", int'(num4), exp);
    tick();
    tick();
  endtask

  initial begin
    int n, trig_cnt, trig_at, done_rise;
    logic prev_done;
    logic signed [7:0] ra, rb;
    int ai, bi;

    tbl[0] = '{8'sd3,    8'sd4,    25};
    tbl[1] = '{-8'sd128, -8'sd128, 32768};
    tbl[2] = '{8'sd127,  -8'sd1,   16130};
    tbl[3] = '{8'sd0,    8'sd0,    0};
    tbl[4] = '{8'sd5,    8'sd12,   169};
    tbl[5] = '{-8'sd7,   8'sd9,    130};
    tbl[6] = '{8'sd1,    -8'sd1,   2};
    tbl[7] = '{-8'sd1,   8'sd0,    1};
    tbl[8] = '{8'sd100,  -8'sd100, 20000};
    tbl[9] = '{-8'sd128, 8'sd127,  32513};

    reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; sqrt_rdy = 1'b1; dx = '0; dy = '0;
    reset4 = 1'b1; en4 = 1'b1; trig4 = 1'b0; srdy4 = 1'b1; dx4 = '0; dy4 = '0;
    tick();
    tick();
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_num", int'(num_out), 0);
    chk("rst_trig", int'(sqrt_trigger), 0);
    reset = 1'b0; reset4 = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_op(tbl[i].dx, tbl[i].dy, tbl[i].exp, "tbl");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ai = ra; bi = rb;
      run_op(ra, rb, ai * ai + bi * bi, "rand");
    end

    // Downstream not ready: hold in WAIT_RDY with a stable result.
    sqrt_rdy = 1'b0;
    dx = -8'sd20; dy = 8'sd15; trigger = 1'b1;
    exp_q.push_back(625);
    tick();
    trigger = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    for (int k = 0; k < 10; k++) begin
      chk("wait_trig", int'(sqrt_trigger), 0);
      chk("wait_flags", int'(rdy || done), 0);
      chk("wait_num", int'(num_out), 625);
      tick();
    end
    sqrt_rdy = 1'b1;
    #1;
    chk("wait_release", int'(sqrt_trigger), 1);
    tick();
    chk("wait_done", int'(done), 1);
    tick();
    chk("wait_rdy", int'(rdy), 1);
    last_res = 625;

    // clk_en toggling: only even edges are enabled after the accept edge.
    dx = 8'sd5; dy = 8'sd12; trigger = 1'b1; clk_en = 1'b1;
    exp_q.push_back(169);
    tick();
    trigger = 1'b0; clk_en = 1'b0;
    trig_cnt = 0; trig_at = 0; done_rise = 0; prev_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      clk_en = (k % 2 == 1);
      #1;
      if (sqrt_trigger) begin trig_cnt++; trig_at = k; end
      if (done && !prev_done) done_rise++;
      prev_done = done;
      if (k == 32) chk("en_wait_suppress", int'(sqrt_trigger || rdy), 0);
      if (k == 36) chk("en_rdy_back", int'(rdy), 1);
    end
    clk_en = 1'b1;
    chk("en_trig_count", trig_cnt, 1);
    chk("en_trig_at", trig_at, 33);
    chk("en_done_count", done_rise, 1);
    last_res = 169;
    tick();

    // Reset in the middle of SQ_Y aborts without a handoff.
    dx = 8'sd9; dy = 8'sd9; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("abort_hold", int'(num_out), last_res);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rdy", int'(rdy), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_num", int'(num_out), 0);
    last_res = 0;
    for (int k = 0; k < 30; k++) tick();
    chk("abort_idle", int'(rdy), 1);

    // Triggers while busy, including a long held trigger, must be ignored.
    dx = 8'sd6; dy = 8'sd8; trigger = 1'b1;
    exp_q.push_back(100);
    tick();
    trigger = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      dx = -8'sd128; dy = -8'sd128;
      trigger = (k == 2) || (k >= 5 && k <= 14);
      tick();
    end
    trigger = 1'b0;
    chk("busy_trig", int'(sqrt_trigger), 1);
    tick();
    chk("busy_done", int'(done), 1);
    tick();
    chk("busy_rdy", int'(rdy), 1);
    last_res = 100;

    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        run4(4'(a), 4'(b), a * a + b * b);

    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
